// File: rtl/instr_fetch.sv
// Fetch stage: synchronous-read instruction store with a programming port,
// program counter, stall/jump/HALT control presenting one instruction per cycle.
module instr_fetch #(
  parameter int unsigned             WIDTH_INSTR  = 28,
  parameter int unsigned             WIDTH_ADDR   = 8,
  parameter int unsigned             WIDTH_OPCODE = 4,
  parameter int unsigned             WIDTH_JDATA  = 24,
  parameter logic [WIDTH_OPCODE-1:0] NOP_OPCODE   = 4'b1101,
  parameter logic [WIDTH_OPCODE-1:0] HALT_OPCODE  = 4'b1111,
  parameter int unsigned             START_ADDR   = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   next_instr,
  input  logic                   jump,
  input  logic [WIDTH_JDATA-1:0] jdata,
  input  logic                   prog_we,
  input  logic [WIDTH_ADDR-1:0]  prog_addr,
  input  logic [WIDTH_INSTR-1:0] prog_wdata,
  output logic [WIDTH_INSTR-1:0] instr,
  output logic                   instr_valid,
  output logic [WIDTH_ADDR-1:0]  pc,
  output logic                   halted
);

  localparam int unsigned DEPTH = 2 ** WIDTH_ADDR;
  localparam logic [WIDTH_INSTR-1:0] NOP_INSTR =
    {NOP_OPCODE, {(WIDTH_INSTR - WIDTH_OPCODE){1'b0}}};
  localparam logic [WIDTH_ADDR-1:0] START_PC = WIDTH_ADDR'(START_ADDR);

  localparam logic [1:0] S_FILL   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [WIDTH_INSTR-1:0] mem_q [DEPTH];

  logic [1:0]             state_q, state_d;
  logic [WIDTH_INSTR-1:0] instr_q;
  logic [WIDTH_ADDR-1:0]  pc_q, pc_d;
  logic                   valid_q, valid_d;
  logic                   halted_q, halted_d;

  logic [WIDTH_ADDR-1:0]   rd_addr_c;
  logic                    load_c;
  logic                    nop_c;
  logic [WIDTH_ADDR-1:0]   target_c;
  logic [WIDTH_OPCODE-1:0] opcode_c;
  logic                    unused_jdata_c;

  assign target_c       = jdata[WIDTH_ADDR-1:0];
  assign opcode_c       = instr_q[WIDTH_INSTR-1 -: WIDTH_OPCODE];
  assign unused_jdata_c = ^jdata[WIDTH_JDATA-1:WIDTH_ADDR];

  // Programming port; contents survive reset.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_q[prog_addr] <= prog_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_FILL;
      pc_q     <= START_PC;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  // Read only when loading, so a stalled instruction is never refreshed.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      instr_q <= NOP_INSTR;
    end else if (load_c) begin
      instr_q <= mem_q[rd_addr_c];
    end else if (nop_c) begin
      instr_q <= NOP_INSTR;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    rd_addr_c = pc_q;
    load_c    = 1'b0;
    nop_c     = 1'b0;
    unique case (state_q)
      S_FILL: begin
        load_c    = 1'b1;
        rd_addr_c = jump ? target_c : START_PC;
        pc_d      = rd_addr_c;
        valid_d   = 1'b1;
        halted_d  = 1'b0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        if (jump) begin
          load_c    = 1'b1;
          rd_addr_c = target_c;
          pc_d      = target_c;
          valid_d   = 1'b1;
        end else if (next_instr) begin
          if (opcode_c == HALT_OPCODE) begin
            nop_c    = 1'b1;
            valid_d  = 1'b0;
            halted_d = 1'b1;
            state_d  = S_HALTED;
          end else begin
            load_c    = 1'b1;
            rd_addr_c = pc_q + WIDTH_ADDR'(1);
            pc_d      = rd_addr_c;
          end
        end
      end
      S_HALTED: begin
        if (jump) begin
          load_c    = 1'b1;
          rd_addr_c = target_c;
          pc_d      = target_c;
          valid_d   = 1'b1;
          halted_d  = 1'b0;
          state_d   = S_RUN;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

endmodule
